// File: rtl/tff_down_counter_ctl.sv
// rtl/tff_down_counter_ctl.sv - loadable T-FF down counter with run-control FSM
//
// Countdown timer / event divider. Software loads a value, starts the counter,
// and watches borrow (registered pulse on each terminal count) and done.
//
// Ports:
//   clk       clock, all state on rising edge
//   rst       asynchronous active-high reset
//   load      load load_val into reload register and counter, go IDLE
//   load_val  value used by load
//   start     IDLE/DONE: counter <= reload register, go RUN (ignored in RUN)
//   stop      RUN: go IDLE with counter held
//   periodic  1 = auto-reload at zero, 0 = one-shot
//   count     current counter value (T flip-flop outputs)
//   zero      count == 0 (combinational)
//   borrow    one-cycle pulse in the cycle after a RUN cycle with count == 0
//   busy      state == RUN
//   done      state == DONE
module tff_down_counter_ctl #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             stop,
    input  logic             periodic,
    output logic [WIDTH-1:0] count,
    output logic             zero,
    output logic             borrow,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] reload_reg;
    logic [WIDTH-1:0] reload_next;
    logic [WIDTH-1:0] set_val;
    logic [WIDTH-1:0] t;
    logic             set_en;
    logic             dec;
    logic             borrow_next;

    // Decision order encodes the edge priority: load > stop > start > count.
    always_comb begin
        state_next  = state;
        reload_next = reload_reg;
        set_en      = 1'b0;
        set_val     = reload_reg;
        dec         = 1'b0;
        borrow_next = 1'b0;

        if (load) begin
            reload_next = load_val;
            set_en      = 1'b1;
            set_val     = load_val;
            state_next  = IDLE;
        end else if (stop && state == RUN) begin
            state_next = IDLE;
        end else if (start && state != RUN) begin
            set_en     = 1'b1;
            set_val    = reload_reg;
            state_next = RUN;
        end else if (state == RUN) begin
            if (q == '0) begin
                // Terminal count: reload or finish; the counter never wraps.
                borrow_next = 1'b1;
                if (periodic) begin
                    set_en = 1'b1;
                end else begin
                    state_next = DONE;
                end
            end else begin
                dec = 1'b1;
            end
        end
    end

    // T-FF toggle enables: bit i toggles when decrementing and all lower bits
    // are zero (they are about to borrow from bit i).
    always_comb begin
        logic low_zero;
        t        = '0;
        low_zero = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            t[i]     = dec & low_zero;
            low_zero = low_zero & ~q[i];
        end
    end

    // Parallel set (load/start/reload) overrides the toggle path.
    assign q_next = set_en ? set_val : (q ^ t);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            q          <= '0;
            reload_reg <= '0;
            borrow     <= 1'b0;
        end else begin
            state      <= state_next;
            q          <= q_next;
            reload_reg <= reload_next;
            borrow     <= borrow_next;
        end
    end

    assign count = q;
    assign zero  = (q == '0);
    assign busy  = (state == RUN);
    assign done  = (state == DONE);

endmodule

// File: tb/tb_tff_down_counter_ctl.sv
// tb/tb_tff_down_counter_ctl.sv - scoreboard bench for tff_down_counter_ctl
module tb_tff_down_counter_ctl;

    logic       clk;
    logic       rst;
    logic       load;
    logic [2:0] load_val;
    logic       start;
    logic       stop;
    logic       periodic;
    logic [2:0] count;
    logic       zero;
    logic       borrow;
    logic       busy;
    logic       done;

    typedef struct packed {
        logic [2:0] count;
        logic       zero;
        logic       borrow;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_checks;
    int    n_fail;

    tff_down_counter_ctl #(.WIDTH(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .start    (start),
        .stop     (stop),
        .periodic (periodic),
        .count    (count),
        .zero     (zero),
        .borrow   (borrow),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [2:0] c, input logic b, input logic bs, input logic d);
        exp_t e;
        e.count  = c;
        e.zero   = (c == 3'd0);
        e.borrow = b;
        e.busy   = bs;
        e.done   = d;
        return e;
    endfunction

    // Monitor: outputs are presented every cycle; compare on the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            exp_t  a;
            string tg;
            e  = exp_q.pop_front();
            tg = tag_q.pop_front();
            a  = {count, zero, borrow, busy, done};
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL %s: got count=%0d zero=%b borrow=%b busy=%b done=%b, expected count=%0d zero=%b borrow=%b busy=%b done=%b",
                         tg, a.count, a.zero, a.borrow, a.busy, a.done,
                         e.count, e.zero, e.borrow, e.busy, e.done);
            end
        end
    end

    // Called at a falling edge: drive inputs, let one rising edge pass, then
    // post the expected outputs for the monitor.
    task automatic cyc(input string tg, input logic ld, input logic [2:0] lv,
                       input logic st, input logic sp, input logic per,
                       input logic [2:0] ec, input logic eb, input logic ebusy,
                       input logic edone);
        load     = ld;
        load_val = lv;
        start    = st;
        stop     = sp;
        periodic = per;
        @(posedge clk);
        #1;
        exp_q.push_back(mk(ec, eb, ebusy, edone));
        tag_q.push_back(tg);
        @(negedge clk);
    endtask

    // Reset asserted in the middle of a cycle; outputs must clear before any edge.
    task automatic rst_mid(input string tg);
        load  = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        #1 rst = 1'b1;
        #1;
        exp_q.push_back(mk(3'd0, 1'b0, 1'b0, 1'b0));
        tag_q.push_back(tg);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        load     = 1'b0;
        load_val = 3'd0;
        start    = 1'b0;
        stop     = 1'b0;
        periodic = 1'b0;
        #1;
        exp_q.push_back(mk(3'd0, 1'b0, 1'b0, 1'b0));
        tag_q.push_back("reset");
        @(negedge clk);
        rst = 1'b0;

        // One-shot countdown from 5
        cyc("os_load",  1, 5, 0, 0, 0, 5, 0, 0, 0);
        cyc("os_start", 0, 0, 1, 0, 0, 5, 0, 1, 0);
        for (int c = 4; c >= 0; c--)
            cyc("os_dec", 0, 0, 0, 0, 0, 3'(c), 0, 1, 0);
        cyc("os_borrow", 0, 0, 0, 0, 0, 0, 1, 0, 1);
        cyc("os_done1",  0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc("os_done2",  0, 0, 0, 0, 0, 0, 0, 0, 1);

        // Periodic reload 2: period of 3
        cyc("per_load",  1, 2, 0, 0, 1, 2, 0, 0, 0);
        cyc("per_start", 0, 0, 1, 0, 1, 2, 0, 1, 0);
        cyc("per_1",     0, 0, 0, 0, 1, 1, 0, 1, 0);
        cyc("per_0",     0, 0, 0, 0, 1, 0, 0, 1, 0);
        cyc("per_rl",    0, 0, 0, 0, 1, 2, 1, 1, 0);
        cyc("per_1b",    0, 0, 0, 0, 1, 1, 0, 1, 0);
        cyc("per_0b",    0, 0, 0, 0, 1, 0, 0, 1, 0);
        cyc("per_rl2",   0, 0, 0, 0, 1, 2, 1, 1, 0);
        cyc("per_1c",    0, 0, 0, 0, 1, 1, 0, 1, 0);

        // Stop holds the count; stop in IDLE is a no-op; restart reloads
        cyc("st_load",   1, 5, 0, 0, 0, 5, 0, 0, 0);
        cyc("st_start",  0, 0, 1, 0, 0, 5, 0, 1, 0);
        cyc("st_4",      0, 0, 0, 0, 0, 4, 0, 1, 0);
        cyc("st_3",      0, 0, 0, 0, 0, 3, 0, 1, 0);
        cyc("st_stop",   0, 0, 0, 1, 0, 3, 0, 0, 0);
        cyc("st_idle",   0, 0, 0, 1, 0, 3, 0, 0, 0);
        cyc("st_restart",0, 0, 1, 0, 0, 5, 0, 1, 0);
        cyc("st_r4",     0, 0, 0, 0, 0, 4, 0, 1, 0);
        cyc("st_r3",     0, 0, 0, 0, 0, 3, 0, 1, 0);
        cyc("st_r2",     0, 0, 0, 0, 0, 2, 0, 1, 0);

        // Load beats start in RUN; stop beats start in RUN
        cyc("ld_start",  1, 6, 1, 0, 0, 6, 0, 0, 0);
        cyc("ld_run",    0, 0, 1, 0, 0, 6, 0, 1, 0);
        cyc("stop_start",0, 0, 1, 1, 0, 6, 0, 0, 0);

        // Async reset mid-RUN at count 4; reload register cleared too
        cyc("rs_start",  0, 0, 1, 0, 0, 6, 0, 1, 0);
        cyc("rs_5",      0, 0, 0, 0, 0, 5, 0, 1, 0);
        cyc("rs_4",      0, 0, 0, 0, 0, 4, 0, 1, 0);
        rst_mid("rs_async");
        cyc("rs_after",  0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("rs_start0", 0, 0, 1, 0, 0, 0, 0, 1, 0);
        cyc("rs_borrow", 0, 0, 0, 0, 0, 0, 1, 0, 1);
        cyc("rs_done",   0, 0, 0, 0, 0, 0, 0, 0, 1);

        // Reload 0 periodic: borrow every RUN cycle; then full range 7
        cyc("z_load",    1, 0, 0, 0, 1, 0, 0, 0, 0);
        cyc("z_start",   0, 0, 1, 0, 1, 0, 0, 1, 0);
        cyc("z_b1",      0, 0, 0, 0, 1, 0, 1, 1, 0);
        cyc("z_b2",      0, 0, 0, 0, 1, 0, 1, 1, 0);
        cyc("z_b3",      0, 0, 0, 0, 1, 0, 1, 1, 0);
        cyc("f_load",    1, 7, 0, 0, 1, 7, 0, 0, 0);
        cyc("f_start",   0, 0, 1, 0, 1, 7, 0, 1, 0);
        for (int c = 6; c >= 0; c--)
            cyc("f_dec", 0, 0, 0, 0, 1, 3'(c), 0, 1, 0);
        cyc("f_reload",  0, 0, 0, 0, 1, 7, 1, 1, 0);
        cyc("f_6",       0, 0, 0, 0, 1, 6, 0, 1, 0);
        cyc("f_start_ign",0, 0, 1, 0, 1, 5, 0, 1, 0);
        cyc("f_stop",    0, 0, 0, 1, 1, 5, 0, 0, 0);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++)
            @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations unchecked, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
